// File: rtl/s9_pkg.sv
// Shared definitions for the s9 universal register: mode encodings and
// the parameter limits.
package s9_pkg;

  localparam int S9_MODE_W    = 3;
  localparam int S9_WIDTH_MIN = 2;
  localparam int S9_WIDTH_MAX = 32;

  typedef enum logic [S9_MODE_W-1:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_INC  = 3'b110,
    MODE_DEC  = 3'b111
  } s9_mode_e;

endpackage

// File: rtl/s9_univ_reg.sv
// s9_univ_reg: WIDTH-bit storage / shift / rotate / count register with a
// complementary output, serial chaining taps, a terminal-count flag and a
// one-cycle wrap pulse.
module s9_univ_reg
  import s9_pkg::*;
#(
  parameter int          WIDTH   = 8,
  parameter logic [31:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             sout_l,
  output logic             sout_r,
  output logic             tc,
  output logic             wrap
);

  // RST_VAL is given 32 bits wide; only the low WIDTH bits are meaningful.
  localparam logic [WIDTH-1:0] RST_Q = RST_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             tc_w;

  // Terminal count: the value the selected count direction is about to wrap from.
  always_comb begin
    tc_w = 1'b0;
    case (mode)
      MODE_INC: tc_w = (q_q == {WIDTH{1'b1}});
      MODE_DEC: tc_w = (q_q == {WIDTH{1'b0}});
      default:  tc_w = 1'b0;
    endcase
  end

  // Next-state selection: clr beats en, en gates every mode operation.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (clr) begin
      q_d    = '0;
      wrap_d = 1'b0;
    end else if (en) begin
      wrap_d = tc_w;
      case (mode)
        MODE_HOLD: q_d = q_q;
        MODE_LOAD: q_d = d;
        MODE_SHL:  q_d = {q_q[WIDTH-2:0], sin_r};
        MODE_SHR:  q_d = {sin_l, q_q[WIDTH-1:1]};
        MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
        MODE_INC:  q_d = q_q + ONE;
        MODE_DEC:  q_d = q_q - ONE;
        default:   q_d = q_q;
      endcase
    end
  end

  // State register; reset forces RST_VAL and drops wrap without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= RST_Q;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q      = q_q;
  assign qb     = ~q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];
  assign tc     = tc_w;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_s9_univ_reg.sv
// Directed bench for s9_univ_reg (WIDTH=8, RST_VAL=8'hA5).
module tb_s9_univ_reg;
  import s9_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, en, clr, sin_l, sin_r;
  logic [2:0]   mode;
  logic [W-1:0] d, q, qb;
  logic         sout_l, sout_r, tc, wrap;

  int n_checks = 0;
  int n_fail   = 0;

  s9_univ_reg #(.WIDTH(W), .RST_VAL(32'h0000_00A5)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .d(d),
    .sin_l(sin_l), .sin_r(sin_r), .q(q), .qb(qb),
    .sout_l(sout_l), .sout_r(sout_r), .tc(tc), .wrap(wrap)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; mode = MODE_HOLD;
    d = '0; sin_l = 1'b0; sin_r = 1'b0;

    // Reset value visible before any clock edge.
    #5;
    chk("rst_q", q, 8'hA5);
    chk("rst_qb", qb, 8'h5A);
    chk("rst_wrap", wrap, 1'b0);
    step();
    chk("rst_q_edge", q, 8'hA5);
    rst = 1'b0; en = 1'b1; mode = MODE_HOLD;
    step();
    chk("hold_q", q, 8'hA5);

    // Load then shift.
    mode = MODE_LOAD; d = 8'h81;
    step();
    chk("load_q", q, 8'h81);
    chk("load_sout_l", sout_l, 1'b1);
    chk("load_sout_r", sout_r, 1'b1);
    mode = MODE_SHL; sin_r = 1'b1;
    step();
    chk("shl_q", q, 8'h03);
    chk("shl_qb", qb, 8'hFC);
    mode = MODE_SHR; sin_l = 1'b0;
    step();
    chk("shr_q", q, 8'h01);
    sin_l = 1'b1;
    step();
    chk("shr_sinl_q", q, 8'h80);

    // Rotate left a full turn.
    mode = MODE_LOAD; d = 8'h81;
    step();
    mode = MODE_ROL;
    step();
    chk("rol1_q", q, 8'h03);
    for (int i = 0; i < 7; i++) step();
    chk("rol8_q", q, 8'h81);
    mode = MODE_ROR;
    step();
    chk("ror1_q", q, 8'hC0);

    // Count up through the wrap.
    mode = MODE_LOAD; d = 8'hFE;
    step();
    mode = MODE_INC;
    #1;
    chk("inc_tc_fe", tc, 1'b0);
    step();
    chk("inc_q_ff", q, 8'hFF);
    chk("inc_tc_ff", tc, 1'b1);
    chk("inc_wrap_pre", wrap, 1'b0);
    step();
    chk("inc_q_wrap", q, 8'h00);
    chk("inc_wrap", wrap, 1'b1);
    chk("inc_tc_00", tc, 1'b0);
    step();
    chk("inc_q_01", q, 8'h01);
    chk("inc_wrap_drop", wrap, 1'b0);

    // Count down through the wrap.
    mode = MODE_DEC;
    #1;
    chk("dec_tc_01", tc, 1'b0);
    step();
    chk("dec_q_00", q, 8'h00);
    chk("dec_tc_00", tc, 1'b1);
    step();
    chk("dec_q_wrap", q, 8'hFF);
    chk("dec_wrap", wrap, 1'b1);
    step();
    chk("dec_q_fe", q, 8'hFE);
    chk("dec_wrap_drop", wrap, 1'b0);

    // tc is only meaningful in the count modes.
    mode = MODE_LOAD; d = 8'hFF;
    step();
    mode = MODE_SHL;
    #1;
    chk("tc_other_mode", tc, 1'b0);
    mode = MODE_INC;
    #1;
    chk("tc_inc_ff", tc, 1'b1);

    // clr beats en, even on a wrapping edge.
    clr = 1'b1;
    step();
    chk("clr_en_q", q, 8'h00);
    chk("clr_en_wrap", wrap, 1'b0);

    // clr with en low.
    mode = MODE_LOAD; d = 8'h5C; clr = 1'b0;
    step();
    chk("preclr_q", q, 8'h5C);
    en = 1'b0; clr = 1'b1;
    step();
    chk("clr_noen_q", q, 8'h00);
    clr = 1'b0;

    // en low freezes a count.
    en = 1'b1; mode = MODE_INC;
    step(); step(); step();
    chk("cnt3_q", q, 8'h03);
    en = 1'b0;
    step(); step();
    chk("frozen_q", q, 8'h03);

    // Reset mid-count, asynchronous.
    en = 1'b1; mode = MODE_LOAD; d = 8'h3F;
    step();
    mode = MODE_INC;
    step();
    chk("pre_rst_q", q, 8'h40);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_q", q, 8'hA5);
    chk("async_rst_qb", qb, 8'h5A);
    step();
    chk("rst_hold_q", q, 8'hA5);
    rst = 1'b0;
    step();
    chk("post_rst_inc_q", q, 8'hA6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
